// File: rtl/cp0_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cp0_pkg : shared CP0 register numbers, exception codes, constants  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package cp0_pkg;

  localparam logic [4:0]  CP0_SR       = 5'd12;
  localparam logic [4:0]  CP0_CAUSE    = 5'd13;
  localparam logic [4:0]  CP0_EPC      = 5'd14;
  localparam logic [4:0]  CP0_PRID     = 5'd15;

  localparam logic [4:0]  EXC_INT      = 5'd0;
  localparam logic [4:0]  EXC_ADEL     = 5'd4;
  localparam logic [4:0]  EXC_ADES     = 5'd5;
  localparam logic [4:0]  EXC_RI       = 5'd10;
  localparam logic [4:0]  EXC_OV       = 5'd12;

  localparam logic [31:0] PRID_VALUE   = 32'h0000_7F00;
  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

endpackage
`default_nettype wire

// File: rtl/cp0_exc_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cp0_exc_ctrl_if : pipeline <-> CP0 exception controller bundle     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface cp0_exc_ctrl_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPCOut;
  logic [31:0] DOut;

  modport master (
    output A1, A2, DIn, WE, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    input  IntReq, EPCOut, DOut
  );

  modport slave (
    input  A1, A2, DIn, WE, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    output IntReq, EPCOut, DOut
  );
endinterface
`default_nettype wire

// File: rtl/cp0_exc_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cp0_exc_ctrl : CP0 SR/Cause/EPC/PRId with exception/interrupt req  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module cp0_exc_ctrl
  import cp0_pkg::*;
(
  input  wire logic     clk,
  input  wire logic     reset,
  cp0_exc_ctrl_if.slave bus
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;

  logic        w_int_pend;
  logic        w_exc_pend;
  logic        w_int_req;
  logic [31:0] w_epc_victim;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic [31:0] w_dout;

  assign w_int_pend = (|(bus.HWInt & r_im)) & r_ie & ~r_exl;
  assign w_exc_pend = (bus.ExcCodeIn != 5'd0) & ~r_exl;
  assign w_int_req  = w_int_pend | w_exc_pend;

  // A delay-slot victim restarts at its branch so the branch is re-executed.
  assign w_epc_victim = bus.BDIn ? (bus.VPC - 32'd4) : bus.VPC;

  assign w_sr    = {16'd0, r_im, 8'd0, r_exl, r_ie};
  assign w_cause = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'd0};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_im      <= '0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= '0;
      r_exccode <= '0;
      r_epc     <= '0;
    end else begin
      r_ip <= bus.HWInt;
      if (w_int_req) begin
        r_exl     <= 1'b1;
        r_bd      <= bus.BDIn;
        r_epc     <= w_epc_victim & 32'hFFFF_FFFC;
        r_exccode <= w_int_pend ? EXC_INT : bus.ExcCodeIn;
      end else begin
        if (bus.WE && (bus.A2 == CP0_SR)) begin
          r_im  <= bus.DIn[15:10];
          r_exl <= bus.DIn[1];
          r_ie  <= bus.DIn[0];
        end
        if (bus.WE && (bus.A2 == CP0_EPC)) begin
          r_epc <= bus.DIn & 32'hFFFF_FFFC;
        end
        // eret is ordered after a same-cycle SR write
        if (bus.EXLClr) begin
          r_exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_dout = '0;
    case (bus.A1)
      CP0_SR:    w_dout = w_sr;
      CP0_CAUSE: w_dout = w_cause;
      CP0_EPC:   w_dout = r_epc;
      CP0_PRID:  w_dout = PRID_VALUE;
      default:   w_dout = '0;
    endcase
  end

  assign bus.IntReq = w_int_req;
  assign bus.EPCOut = r_epc;
  assign bus.DOut   = w_dout;

endmodule
`default_nettype wire
